intc: RTL

INTC -- requirements
Module: intc

---
 rtl/intc.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/intc.sv
// 8-source interrupt controller with PEND/ENA/ISRC registers on a 16-bit CPU bus.
// Define INTC_EDGE_EN for rising-edge capture of sources; the default build mirrors source levels.
module intc #(
    parameter int unsigned               ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]     BASE_ADDR  = 'h020
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  rd_mem,
    input  logic                  wr_mem,
    input  logic                  byt,
    input  logic [15:0]           wr_data,
    output logic [15:0]           rd_data,
    output logic                  rd_hit,
    input  logic [7:0]            src_irq,
    output logic                  irq
);

    localparam logic [ADDR_WIDTH-2:0] PEND_WA = BASE_ADDR[ADDR_WIDTH-1:1];
    localparam logic [ADDR_WIDTH-2:0] ENA_WA  = PEND_WA + (ADDR_WIDTH-1)'(1);
    localparam logic [ADDR_WIDTH-2:0] ISRC_WA = PEND_WA + (ADDR_WIDTH-1)'(2);

    function automatic logic [2:0] low_idx(input logic [7:0] v);
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) low_idx = 3'(i);
        end
    endfunction

    logic [7:0]  pend_q, pend_d;
    logic [7:0]  ena_q, ena_d;
    logic        irq_q;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_hit_q, rd_hit_d;

    logic        hit_pend_s, hit_ena_s, hit_isrc_s;
    logic        wr_lo_s, wr_pend_s, wr_ena_s, wr_isrc_s;
    logic [7:0]  active_s;
    logic [2:0]  isrc_idx_s;
    logic [15:0] isrc_val_s;
    logic        unused_s;

    assign hit_pend_s = (mem_addr[ADDR_WIDTH-1:1] == PEND_WA);
    assign hit_ena_s  = (mem_addr[ADDR_WIDTH-1:1] == ENA_WA);
    assign hit_isrc_s = (mem_addr[ADDR_WIDTH-1:1] == ISRC_WA);

    // Upper-byte writes carry no register bits, so they are dropped entirely.
    assign wr_lo_s   = wr_mem & ~(byt & mem_addr[0]);
    assign wr_pend_s = wr_lo_s & hit_pend_s;
    assign wr_ena_s  = wr_lo_s & hit_ena_s;
    assign wr_isrc_s = wr_lo_s & hit_isrc_s;

    assign active_s   = pend_q & ena_q;
    assign isrc_idx_s = low_idx(active_s);
    assign isrc_val_s = {|active_s, 12'h000, isrc_idx_s};

`ifdef INTC_EDGE_EN
    logic [7:0] hist_q;
    logic [7:0] rise_s;
    logic [7:0] clr_s;

    assign rise_s   = src_irq & ~hist_q;
    assign unused_s = ^wr_data[15:8];

    // Clear mask from W1C writes and the ISRC-acknowledge of the reported source.
    always_comb begin
        clr_s = 8'h00;
        if (wr_pend_s) begin
            clr_s = wr_data[7:0];
        end else if (wr_isrc_s && (|active_s)) begin
            clr_s = 8'h01 << isrc_idx_s;
        end else begin
            clr_s = 8'h00;
        end
    end

    // Edge capture: a new rising edge overrides a same-cycle clear.
    always_comb begin
        pend_d = (pend_q & ~clr_s) | rise_s;
    end

    // Source history, preset high so sources already asserted at reset release are ignored.
    always_ff @(posedge clk) begin
        if (rst) hist_q <= 8'hFF;
        else     hist_q <= src_irq;
    end
`else
    assign unused_s = ^{wr_data[15:8], wr_pend_s, wr_isrc_s};

    // Level mode: pending flags simply follow the sources.
    always_comb begin
        pend_d = src_irq;
    end
`endif

    // Enable mask load.
    always_comb begin
        if (wr_ena_s) ena_d = wr_data[7:0];
        else          ena_d = ena_q;
    end

    // Read response captures the pre-write register value of this cycle.
    always_comb begin
        rd_hit_d  = 1'b0;
        rd_data_d = 16'h0000;
        if (rd_mem && hit_pend_s) begin
            rd_hit_d  = 1'b1;
            rd_data_d = {8'h00, pend_q};
        end else if (rd_mem && hit_ena_s) begin
            rd_hit_d  = 1'b1;
            rd_data_d = {8'h00, ena_q};
        end else if (rd_mem && hit_isrc_s) begin
            rd_hit_d  = 1'b1;
            rd_data_d = isrc_val_s;
        end else begin
            rd_hit_d  = 1'b0;
            rd_data_d = 16'h0000;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= 8'h00;
            ena_q     <= 8'h00;
            irq_q     <= 1'b0;
            rd_data_q <= 16'h0000;
            rd_hit_q  <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            ena_q     <= ena_d;
            irq_q     <= |active_s;
            rd_data_q <= rd_data_d;
            rd_hit_q  <= rd_hit_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_hit  = rd_hit_q;
    assign irq     = irq_q;

endmodule
